// File: rtl/lsu_bus_clken_gen.sv
// LSU bus clock-enable generator: one lsu_bus_clk_en pulse every (bus_ratio_q+1) core clocks.
// Latency: request accepted at t -> earliest new ratio on bus_ratio_q at t+3 (DRAIN, SWITCH).
// Backpressure: ratio_req_ready is low from DRAIN until the switch completes; requester holds valid.
module lsu_bus_clken_gen #(
    parameter int                 RATIO_W       = 3,
    parameter logic [RATIO_W-1:0] DEFAULT_RATIO = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ratio_req_valid,
    input  logic [RATIO_W-1:0] ratio_req,
    output logic               ratio_req_ready,
    input  logic               lsu_bus_buffer_empty_any,
    output logic               lsu_bus_clk_en,
    output logic [RATIO_W-1:0] bus_ratio_q,
    output logic               ratio_switch_busy,
    output logic               ratio_switch_done
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] ratio_pend;
    logic               req_accept;

    // Decoded purely from flops so the gated bus clocks see no input-to-enable path.
    assign lsu_bus_clk_en    = (cnt == bus_ratio_q) && (state_q != SWITCH);
    assign ratio_switch_busy = (state_q != RUN);
    assign req_accept        = ratio_req_valid && ratio_req_ready;

    always_comb begin
        state_d           = state_q;
        ratio_req_ready   = 1'b0;
        ratio_switch_done = 1'b0;
        case (state_q)
            RUN: begin
                ratio_req_ready = 1'b1;
                if (ratio_req_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Only leave on a bus-clock boundary with the buffer empty in that same cycle.
                if (lsu_bus_clk_en && lsu_bus_buffer_empty_any) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                ratio_switch_done = 1'b1;
                state_d           = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt         <= '0;
            bus_ratio_q <= DEFAULT_RATIO;
            ratio_pend  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == SWITCH) || lsu_bus_clk_en) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state_q == SWITCH) begin
                bus_ratio_q <= ratio_pend;
            end
            if (req_accept) begin
                ratio_pend <= ratio_req;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_clken_gen.sv
// Directed bench for lsu_bus_clken_gen (RATIO_W=3, DEFAULT_RATIO=2); expected values hand-traced.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_lsu_bus_clken_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       ratio_req_valid;
    logic [2:0] ratio_req;
    logic       ratio_req_ready;
    logic       lsu_bus_buffer_empty_any;
    logic       lsu_bus_clk_en;
    logic [2:0] bus_ratio_q;
    logic       ratio_switch_busy;
    logic       ratio_switch_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    lsu_bus_clken_gen #(
        .RATIO_W       (3),
        .DEFAULT_RATIO (3'd2)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .ratio_req_valid          (ratio_req_valid),
        .ratio_req                (ratio_req),
        .ratio_req_ready          (ratio_req_ready),
        .lsu_bus_buffer_empty_any (lsu_bus_buffer_empty_any),
        .lsu_bus_clk_en           (lsu_bus_clk_en),
        .bus_ratio_q              (bus_ratio_q),
        .ratio_switch_busy        (ratio_switch_busy),
        .ratio_switch_done        (ratio_switch_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue a request from RUN, wait (bounded) for done, land on the first RUN cycle of the new ratio.
    task automatic do_switch(input logic [2:0] val);
        int n;
        ratio_req_valid = 1'b1;
        ratio_req       = val;
        step();
        ratio_req_valid = 1'b0;
        n = 0;
        while (!ratio_switch_done && n < 40) begin
            step();
            n++;
        end
        chk("sw_done", ratio_switch_done, 1);
        step();
        chk("sw_ratio", bus_ratio_q, val);
    endtask

    initial begin
        int done_cnt;
        rst                      = 1'b1;
        ratio_req_valid          = 1'b0;
        ratio_req                = 3'd0;
        lsu_bus_buffer_empty_any = 1'b1;
        step();
        step();

        // Reset defaults: cycle 0 is this cycle, pulses at 2, 5, 8.
        chk("rst_ratio", bus_ratio_q, 2);
        chk("rst_ready", ratio_req_ready, 1);
        chk("rst_busy", ratio_switch_busy, 0);
        chk("rst_done", ratio_switch_done, 0);
        rst = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            chk("rst_en", lsu_bus_clk_en, (i == 2 || i == 5 || i == 8));
            step();
        end

        // Move to divide-by-1, then switch to 3 with an empty buffer.
        do_switch(3'd0);
        chk("r0_en", lsu_bus_clk_en, 1);
        ratio_req_valid = 1'b1;
        ratio_req       = 3'd3;
        chk("sw_t_ready", ratio_req_ready, 1);
        step();
        ratio_req_valid = 1'b0;
        chk("sw_t1_busy", ratio_switch_busy, 1);
        chk("sw_t1_ready", ratio_req_ready, 0);
        chk("sw_t1_en", lsu_bus_clk_en, 1);
        step();
        chk("sw_t2_done", ratio_switch_done, 1);
        chk("sw_t2_en", lsu_bus_clk_en, 0);
        chk("sw_t2_ratio", bus_ratio_q, 0);
        step();
        chk("sw_t3_ratio", bus_ratio_q, 3);
        chk("sw_t3_ready", ratio_req_ready, 1);
        chk("sw_t3_done", ratio_switch_done, 0);
        for (int k = 3; k <= 10; k++) begin
            chk("sw_en", lsu_bus_clk_en, (k == 6 || k == 10));
            step();
        end

        // Drain hold: ratio 1, request 0, buffer busy for 7 cycles.
        do_switch(3'd1);
        ratio_req_valid          = 1'b1;
        ratio_req                = 3'd0;
        lsu_bus_buffer_empty_any = 1'b0;
        chk("dh_u_en", lsu_bus_clk_en, 0);
        step();
        ratio_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("dh_busy", ratio_switch_busy, 1);
            chk("dh_done", ratio_switch_done, 0);
            chk("dh_en", lsu_bus_clk_en, (k % 2 == 1));
            if (k < 6) step();
        end
        lsu_bus_buffer_empty_any = 1'b1;
        step();
        chk("dh_u7_en", lsu_bus_clk_en, 1);
        chk("dh_u7_done", ratio_switch_done, 0);
        step();
        chk("dh_u8_done", ratio_switch_done, 1);
        chk("dh_u8_en", lsu_bus_clk_en, 0);
        step();
        chk("dh_u9_ratio", bus_ratio_q, 0);
        chk("dh_u9_en", lsu_bus_clk_en, 1);

        // Back-pressure: valid held through DRAIN/SWITCH with a changed value.
        ratio_req_valid = 1'b1;
        ratio_req       = 3'd5;
        step();
        ratio_req = 3'd4;
        chk("bp_v1_ready", ratio_req_ready, 0);
        step();
        chk("bp_v2_done", ratio_switch_done, 1);
        chk("bp_v2_ready", ratio_req_ready, 0);
        step();
        chk("bp_v3_ratio", bus_ratio_q, 5);
        chk("bp_v3_ready", ratio_req_ready, 1);
        step();
        ratio_req_valid = 1'b0;
        chk("bp_v4_busy", ratio_switch_busy, 1);
        for (int k = 4; k <= 9; k++) begin
            chk("bp_done", ratio_switch_done, (k == 9));
            chk("bp_ratio", bus_ratio_q, 5);
            step();
        end
        chk("bp_v10_ratio", bus_ratio_q, 4);

        // Reset mid-DRAIN with a pending 5.
        ratio_req_valid          = 1'b1;
        ratio_req                = 3'd5;
        lsu_bus_buffer_empty_any = 1'b0;
        step();
        ratio_req_valid = 1'b0;
        chk("rd_busy", ratio_switch_busy, 1);
        rst = 1'b1;
        step();
        chk("rd_ratio", bus_ratio_q, 2);
        chk("rd_ready", ratio_req_ready, 1);
        chk("rd_busy0", ratio_switch_busy, 0);
        rst                      = 1'b0;
        lsu_bus_buffer_empty_any = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk("rd_done", ratio_switch_done, 0);
            chk("rd_en", lsu_bus_clk_en, (k == 4));
            chk("rd_hold", bus_ratio_q, 2);
            step();
        end

        // Same-value request: full sequence, one done, one missing enable.
        ratio_req_valid = 1'b1;
        ratio_req       = 3'd2;
        done_cnt        = 0;
        for (int k = 0; k <= 6; k++) begin
            chk("sv_en", lsu_bus_clk_en, (k == 1 || k == 5));
            chk("sv_done", ratio_switch_done, (k == 2));
            if (ratio_switch_done) done_cnt++;
            if (k == 3) chk("sv_ratio", bus_ratio_q, 2);
            step();
            ratio_req_valid = 1'b0;
        end
        chk("sv_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
